// File: rtl/ps2_ipif_pkg.sv
// ============================================================================
// ps2_ipif_pkg : shared encodings for the multi-channel PS/2 OPB slave IPIF
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ps2_ipif_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_REQ    = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_RESP   = 3'd4;

  localparam logic [2:0] REG_ISR = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_GIE = 3'd2;

  localparam int CH_STRIDE_LOG2 = 12;

  typedef struct packed {
    logic ack;
    logic err;
    logic retry;
  } resp_t;

  // The slot one past the last PS/2 channel holds the local interrupt registers.
  function automatic logic is_local_slot(input logic [3:0] ch, input int num_ch);
    return ch == 4'(num_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_intr_ctrl.sv
// ============================================================================
// ps2_intr_ctrl : per-channel edge capture, ISR/IER/GIE and merged interrupt
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ps2_intr_ctrl
  import ps2_ipif_pkg::*;
#(
  parameter int C_NUM_CH = 2,
  parameter int C_DWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [C_NUM_CH-1:0] intr_in,
  input  logic                wr_en,
  input  logic [2:0]          reg_sel,
  input  logic [C_DWIDTH-1:0] wdata,
  output logic [C_DWIDTH-1:0] rdata,
  output logic                sys_intr
);

  logic [C_NUM_CH-1:0] intr_prev_q;
  logic [C_NUM_CH-1:0] isr_q, isr_d;
  logic [C_NUM_CH-1:0] ier_q, ier_d;
  logic [C_NUM_CH-1:0] rise;
  logic                gie_q, gie_d;
  logic                sys_intr_q, sys_intr_d;
  logic                unused_wdata;

  assign unused_wdata = &{1'b0, wdata};

  always_comb begin
    rise  = intr_in & ~intr_prev_q;
    isr_d = isr_q;
    ier_d = ier_q;
    gie_d = gie_q;
    if (wr_en) begin
      case (reg_sel)
        REG_ISR: isr_d = isr_q & ~wdata[C_NUM_CH-1:0];
        REG_IER: ier_d = wdata[C_NUM_CH-1:0];
        REG_GIE: gie_d = wdata[0];
        default: ;
      endcase
    end
    // A new edge in the same cycle as a write-1-to-clear must not be lost.
    isr_d      = isr_d | rise;
    sys_intr_d = gie_q & (|(isr_q & ier_q));
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_ISR: rdata = C_DWIDTH'(isr_q);
      REG_IER: rdata = C_DWIDTH'(ier_q);
      REG_GIE: rdata = C_DWIDTH'(gie_q);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_prev_q <= '0;
      isr_q       <= '0;
      ier_q       <= '0;
      gie_q       <= 1'b0;
      sys_intr_q  <= 1'b0;
    end else begin
      intr_prev_q <= intr_in;
      isr_q       <= isr_d;
      ier_q       <= ier_d;
      gie_q       <= gie_d;
      sys_intr_q  <= sys_intr_d;
    end
  end

  assign sys_intr = sys_intr_q;

endmodule

`default_nettype wire

// File: rtl/opb_ipif_slv_ps2_reg_multi.sv
// ============================================================================
// opb_ipif_slv_ps2_reg_multi : OPB slave IPIF for a bank of PS/2 controllers
// Revision                   : 1.0
// ============================================================================
`default_nettype none

module opb_ipif_slv_ps2_reg_multi
  import ps2_ipif_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'hA900_0000,
  parameter int          C_NUM_CH      = 2,
  parameter int          C_DWIDTH      = 8,
  parameter int          C_ACK_TIMEOUT = 16
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [31:0]             OPB_ABus,
  input  logic [3:0]              OPB_BE,
  input  logic [31:0]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [31:0]             Sl_DBus,
  output logic                    Sl_DBusEn,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sys_Intr,
  input  logic [C_DWIDTH-1:0]     IP2Bus_Data,
  input  logic                    IP2Bus_RdAck,
  input  logic                    IP2Bus_WrAck,
  input  logic                    IP2Bus_Error,
  input  logic                    IP2Bus_Retry,
  input  logic                    IP2Bus_ToutSup,
  input  logic [C_NUM_CH-1:0]     IP2Bus_Intr,
  output logic [31:0]             Bus2IP_Addr,
  output logic [3:0]              Bus2IP_BE,
  output logic [C_DWIDTH-1:0]     Bus2IP_Data,
  output logic [C_NUM_CH*8-1:0]   Bus2IP_RegCE,
  output logic                    Bus2IP_RdReq,
  output logic                    Bus2IP_WrReq
);

  localparam int         CE_W     = C_NUM_CH * 8;
  localparam logic [3:0] LOCAL_CH = 4'(C_NUM_CH);
  localparam logic [7:0] TO_LAST  = 8'(C_ACK_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [C_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [C_DWIDTH-1:0]   rdata_q, rdata_d;
  logic                  rnw_q, rnw_d;
  logic                  local_q, local_d;
  logic [CE_W-1:0]       ce_q, ce_d;
  logic [7:0]            cnt_q, cnt_d;
  resp_t                 resp_q, resp_d;
  logic                  tout_q;

  logic [3:0]            dec_ch;
  logic [2:0]            dec_reg;
  logic                  dec_hit;
  logic                  dec_local;
  logic [CE_W-1:0]       dec_ce;
  logic                  ip_ack;
  logic                  loc_we;
  logic [C_DWIDTH-1:0]   loc_rdata;
  logic                  unused_in;

  assign unused_in = &{1'b0, OPB_seqAddr, OPB_DBus};

  // OPB numbers bits MSB-first: ABus[0:15] is addr[31:16], ch is ABus[16:19], reg is ABus[27:29].
  always_comb begin
    dec_ch    = OPB_ABus[CH_STRIDE_LOG2 +: 4];
    dec_reg   = OPB_ABus[4:2];
    dec_local = is_local_slot(dec_ch, C_NUM_CH);
    dec_hit   = (OPB_ABus[31:16] == C_BASEADDR[31:16]) && (dec_ch <= LOCAL_CH) &&
                (OPB_ABus[11:5] == 7'd0);
    for (int i = 0; i < CE_W; i++) begin
      dec_ce[i] = !dec_local && (7'(i) == {dec_ch, dec_reg});
    end
  end

  assign ip_ack = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rnw_d   = rnw_q;
    local_d = local_q;
    ce_d    = ce_q;
    cnt_d   = cnt_q;
    resp_d  = '0;
    loc_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (OPB_select && dec_hit) begin
          state_d = S_DECODE;
          addr_d  = OPB_ABus;
          be_d    = OPB_BE;
          wdata_d = OPB_DBus[31 -: C_DWIDTH];
          rnw_d   = OPB_RNW;
          local_d = dec_local;
          ce_d    = dec_ce;
        end
      end
      S_DECODE: begin
        if (!OPB_select) begin
          state_d = S_IDLE;
          ce_d    = '0;
        end else if (local_q) begin
          state_d    = S_RESP;
          rdata_d    = loc_rdata;
          loc_we     = !rnw_q;
          resp_d.ack = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!OPB_select) begin
          state_d = S_IDLE;
          ce_d    = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        if (!OPB_select) begin
          state_d = S_IDLE;
          ce_d    = '0;
        end else if (ip_ack) begin
          state_d    = S_RESP;
          rdata_d    = IP2Bus_Data;
          resp_d.ack = 1'b1;
          resp_d.err = IP2Bus_Error;
        end else if (IP2Bus_Retry) begin
          state_d      = S_RESP;
          resp_d.retry = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_RESP;
          resp_d.ack = 1'b1;
          resp_d.err = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ce_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
        ce_d    = '0;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rnw_q   <= 1'b0;
      local_q <= 1'b0;
      ce_q    <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rnw_q   <= rnw_d;
      local_q <= local_d;
      ce_q    <= ce_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      tout_q  <= IP2Bus_ToutSup;
    end
  end

  ps2_intr_ctrl #(
    .C_NUM_CH (C_NUM_CH),
    .C_DWIDTH (C_DWIDTH)
  ) u_intr (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .intr_in  (IP2Bus_Intr),
    .wr_en    (loc_we),
    .reg_sel  (addr_q[4:2]),
    .wdata    (wdata_q),
    .rdata    (loc_rdata),
    .sys_intr (Sys_Intr)
  );

  assign Sl_DBusEn    = 1'b1;
  assign Sl_xferAck   = resp_q.ack;
  assign Sl_errAck    = resp_q.err;
  assign Sl_retry     = resp_q.retry;
  assign Sl_DBus      = (resp_q.ack && rnw_q) ? (32'(rdata_q) << (32 - C_DWIDTH)) : 32'd0;
  assign Sl_toutSup   = tout_q && ((state_q == S_REQ) || (state_q == S_WAIT));
  assign Bus2IP_Addr  = addr_q;
  assign Bus2IP_BE    = be_q;
  assign Bus2IP_Data  = wdata_q;
  assign Bus2IP_RegCE = ce_q;
  assign Bus2IP_RdReq = (state_q == S_REQ) && rnw_q;
  assign Bus2IP_WrReq = (state_q == S_REQ) && !rnw_q;

endmodule

`default_nettype wire

// File: tb/tb_opb_ipif_slv_ps2_reg_multi.sv
// ============================================================================
// tb_opb_ipif_slv_ps2_reg_multi : directed bench for the PS/2 OPB slave IPIF
// Revision                      : 1.0
// ============================================================================
`default_nettype none

module tb_opb_ipif_slv_ps2_reg_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] OPB_ABus, OPB_DBus;
  logic [3:0]  OPB_BE;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic [31:0] Sl_DBus;
  logic        Sl_DBusEn, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, Sys_Intr;
  logic [7:0]  IP2Bus_Data;
  logic        IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error, IP2Bus_Retry, IP2Bus_ToutSup;
  logic [1:0]  IP2Bus_Intr;
  logic [31:0] Bus2IP_Addr;
  logic [3:0]  Bus2IP_BE;
  logic [7:0]  Bus2IP_Data;
  logic [15:0] Bus2IP_RegCE;
  logic        Bus2IP_RdReq, Bus2IP_WrReq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  opb_ipif_slv_ps2_reg_multi dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_DBusEn(Sl_DBusEn), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup), .Sys_Intr(Sys_Intr),
    .IP2Bus_Data(IP2Bus_Data), .IP2Bus_RdAck(IP2Bus_RdAck), .IP2Bus_WrAck(IP2Bus_WrAck),
    .IP2Bus_Error(IP2Bus_Error), .IP2Bus_Retry(IP2Bus_Retry), .IP2Bus_ToutSup(IP2Bus_ToutSup),
    .IP2Bus_Intr(IP2Bus_Intr), .Bus2IP_Addr(Bus2IP_Addr), .Bus2IP_BE(Bus2IP_BE),
    .Bus2IP_Data(Bus2IP_Data), .Bus2IP_RegCE(Bus2IP_RegCE),
    .Bus2IP_RdReq(Bus2IP_RdReq), .Bus2IP_WrReq(Bus2IP_WrReq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one OPB beat with a reactive IP model; cyc counts the select-sampled cycle as 1.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                      input int ack_after, input logic [7:0] ack_data, input logic ack_en,
                      input logic err_en, input logic retry_en, input int max_cyc,
                      output logic got_ack, output logic got_err, output logic got_retry,
                      output logic [31:0] got_data, output int cyc, output int reqs,
                      output int ce_cycles);
    int   wc;
    logic active;
    got_ack = 0; got_err = 0; got_retry = 0; got_data = '0;
    cyc = 1; reqs = 0; ce_cycles = 0; wc = 0; active = 0;
    OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wd; OPB_select = 1;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      IP2Bus_RdAck = 0; IP2Bus_WrAck = 0; IP2Bus_Error = 0; IP2Bus_Retry = 0;
      if (|Bus2IP_RegCE) ce_cycles++;
      if (Sl_xferAck || Sl_retry) begin
        got_ack = Sl_xferAck; got_err = Sl_errAck; got_retry = Sl_retry; got_data = Sl_DBus;
        break;
      end
      if (Bus2IP_RdReq || Bus2IP_WrReq) begin
        reqs++; active = 1; wc = 0;
      end else if (active) begin
        wc++;
        if (wc == ack_after) begin
          if (ack_en) begin
            if (rnw) IP2Bus_RdAck = 1; else IP2Bus_WrAck = 1;
          end
          IP2Bus_Error = err_en; IP2Bus_Retry = retry_en; IP2Bus_Data = ack_data;
        end
      end
    end
    OPB_select = 0; OPB_ABus = '0; OPB_RNW = 0; OPB_DBus = '0;
  endtask

  task automatic test_reset();
    total++; if (Sl_xferAck !== 1'b0) begin $display("FAIL rst_xferack got=%b exp=0", Sl_xferAck); bad++; end
    total++; if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin $display("FAIL rst_resp got=%b exp=000", {Sl_errAck, Sl_retry, Sl_toutSup}); bad++; end
    total++; if (Sl_DBus !== 32'h0) begin $display("FAIL rst_dbus got=%h exp=0", Sl_DBus); bad++; end
    total++; if (Sl_DBusEn !== 1'b1) begin $display("FAIL rst_dbusen got=%b exp=1", Sl_DBusEn); bad++; end
    total++; if (Sys_Intr !== 1'b0) begin $display("FAIL rst_sysintr got=%b exp=0", Sys_Intr); bad++; end
    total++; if ({Bus2IP_RegCE, Bus2IP_RdReq, Bus2IP_WrReq} !== 18'h0) begin $display("FAIL rst_ce_req got=%h exp=0", {Bus2IP_RegCE, Bus2IP_RdReq, Bus2IP_WrReq}); bad++; end
    total++; if ({Bus2IP_Addr, Bus2IP_BE, Bus2IP_Data} !== 44'h0) begin $display("FAIL rst_latches got=%h exp=0", {Bus2IP_Addr, Bus2IP_BE, Bus2IP_Data}); bad++; end
  endtask

  task automatic test_read();
    int rdreqs = 0;
    OPB_ABus = 32'hA900_1008; OPB_RNW = 1; OPB_BE = 4'hF; OPB_select = 1;
    tick();  // cycle 2: DECODE
    total++; if (Bus2IP_RegCE !== 16'h0400) begin $display("FAIL read_ce got=%h exp=0400", Bus2IP_RegCE); bad++; end
    total++; if (Bus2IP_Addr !== 32'hA900_1008) begin $display("FAIL read_addr got=%h exp=a9001008", Bus2IP_Addr); bad++; end
    if (Bus2IP_RdReq) rdreqs++;
    tick();  // cycle 3: REQ
    total++; if (Bus2IP_RdReq !== 1'b1) begin $display("FAIL read_rdreq got=%b exp=1", Bus2IP_RdReq); bad++; end
    if (Bus2IP_RdReq) rdreqs++;
    tick();  // cycle 4: WAIT, IP acks now
    if (Bus2IP_RdReq) rdreqs++;
    total++; if (Sl_xferAck !== 1'b0) begin $display("FAIL read_early_ack got=%b exp=0", Sl_xferAck); bad++; end
    IP2Bus_RdAck = 1; IP2Bus_Data = 8'h5A;
    tick();  // cycle 5: RESP
    IP2Bus_RdAck = 0;
    if (Bus2IP_RdReq) rdreqs++;
    total++; if ({Sl_xferAck, Sl_errAck, Sl_retry} !== 3'b100) begin $display("FAIL read_resp got=%b exp=100", {Sl_xferAck, Sl_errAck, Sl_retry}); bad++; end
    total++; if (Sl_DBus !== 32'h5A00_0000) begin $display("FAIL read_data got=%h exp=5a000000", Sl_DBus); bad++; end
    OPB_select = 0;
    tick();
    total++; if ({Sl_xferAck, Sl_DBus} !== 33'h0) begin $display("FAIL read_after got=%h exp=0", {Sl_xferAck, Sl_DBus}); bad++; end
    total++; if (Bus2IP_RegCE !== 16'h0) begin $display("FAIL read_ce_clr got=%h exp=0", Bus2IP_RegCE); bad++; end
    total++; if (rdreqs !== 1) begin $display("FAIL read_req_pulses got=%0d exp=1", rdreqs); bad++; end
  endtask

  task automatic test_write_err();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    xfer(32'hA900_0004, 0, 32'h3C00_0000, 1, 8'h00, 1, 1, 0, 40, a, e, r, d, c, q, ce);
    total++; if (Bus2IP_Data !== 8'h3C) begin $display("FAIL wr_data got=%h exp=3c", Bus2IP_Data); bad++; end
    total++; if ({a, e, r} !== 3'b110) begin $display("FAIL wr_err_resp got=%b exp=110", {a, e, r}); bad++; end
    total++; if (c !== 5 || q !== 1) begin $display("FAIL wr_timing got=cyc%0d/req%0d exp=cyc5/req1", c, q); bad++; end
    total++; if (d !== 32'h0) begin $display("FAIL wr_dbus got=%h exp=0", d); bad++; end
    tick();
    total++; if ({Sl_xferAck, Sl_errAck} !== 2'b00) begin $display("FAIL wr_one_cycle got=%b exp=00", {Sl_xferAck, Sl_errAck}); bad++; end
  endtask

  task automatic test_timeout();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    xfer(32'hA900_0000, 1, 32'h0, 0, 8'h00, 0, 0, 0, 60, a, e, r, d, c, q, ce);
    total++; if ({a, e, r} !== 3'b110) begin $display("FAIL to_resp got=%b exp=110", {a, e, r}); bad++; end
    total++; if (c !== 20) begin $display("FAIL to_cycle got=%0d exp=20", c); bad++; end
    tick();
    total++; if ({Sl_xferAck, Sl_errAck} !== 2'b00) begin $display("FAIL to_one_cycle got=%b exp=00", {Sl_xferAck, Sl_errAck}); bad++; end
    xfer(32'hA900_100C, 1, 32'h0, 2, 8'hC3, 1, 0, 0, 40, a, e, r, d, c, q, ce);
    total++; if ({a, e, r} !== 3'b100 || c !== 6) begin $display("FAIL to_next_xfer got=%b/cyc%0d exp=100/cyc6", {a, e, r}, c); bad++; end
    total++; if (d !== 32'hC300_0000) begin $display("FAIL to_next_data got=%h exp=c3000000", d); bad++; end
    tick();
  endtask

  task automatic test_retry();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    xfer(32'hA900_0010, 1, 32'h0, 1, 8'h11, 0, 0, 1, 40, a, e, r, d, c, q, ce);
    total++; if ({a, e, r} !== 3'b001 || c !== 5) begin $display("FAIL retry_only got=%b/cyc%0d exp=001/cyc5", {a, e, r}, c); bad++; end
    tick();
    total++; if (Sl_retry !== 1'b0) begin $display("FAIL retry_one_cycle got=%b exp=0", Sl_retry); bad++; end
    xfer(32'hA900_0010, 1, 32'h0, 1, 8'h77, 1, 0, 1, 40, a, e, r, d, c, q, ce);
    total++; if ({a, e, r} !== 3'b100) begin $display("FAIL ack_beats_retry got=%b exp=100", {a, e, r}); bad++; end
    total++; if (d !== 32'h7700_0000) begin $display("FAIL ack_retry_data got=%h exp=77000000", d); bad++; end
    tick();
  endtask

  task automatic test_interrupts();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    xfer(32'hA900_2004, 0, 32'h0300_0000, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    total++; if (a !== 1'b1 || c !== 3 || q !== 0 || ce !== 0) begin $display("FAIL local_wr got=ack%b/cyc%0d/req%0d/ce%0d exp=1/3/0/0", a, c, q, ce); bad++; end
    tick();
    xfer(32'hA900_2008, 0, 32'h0100_0000, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    tick();
    xfer(32'hA900_2004, 1, 32'h0, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    total++; if (d !== 32'h0300_0000) begin $display("FAIL ier_rd got=%h exp=03000000", d); bad++; end
    tick();
    total++; if (Sys_Intr !== 1'b0) begin $display("FAIL intr_idle got=%b exp=0", Sys_Intr); bad++; end
    IP2Bus_Intr = 2'b10;
    tick(); tick();
    total++; if (Sys_Intr !== 1'b1) begin $display("FAIL intr_set got=%b exp=1", Sys_Intr); bad++; end
    xfer(32'hA900_2000, 1, 32'h0, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    total++; if (d !== 32'h0200_0000) begin $display("FAIL isr_rd got=%h exp=02000000", d); bad++; end
    tick();
    xfer(32'hA900_2000, 0, 32'h0200_0000, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    tick();
    total++; if (Sys_Intr !== 1'b0) begin $display("FAIL intr_clr got=%b exp=0", Sys_Intr); bad++; end
    IP2Bus_Intr = 2'b00;
    tick();
    OPB_ABus = 32'hA900_2000; OPB_RNW = 0; OPB_DBus = 32'h0200_0000; OPB_select = 1;
    tick();  // DECODE: clear write and new edge land together
    IP2Bus_Intr = 2'b10;
    tick();
    total++; if (Sl_xferAck !== 1'b1) begin $display("FAIL clr_edge_ack got=%b exp=1", Sl_xferAck); bad++; end
    OPB_select = 0; OPB_DBus = '0;
    tick(); tick();
    xfer(32'hA900_2000, 1, 32'h0, 0, 8'h0, 0, 0, 0, 20, a, e, r, d, c, q, ce);
    total++; if (d !== 32'h0200_0000) begin $display("FAIL set_wins got=%h exp=02000000", d); bad++; end
    tick();
    total++; if (Sys_Intr !== 1'b1) begin $display("FAIL set_wins_intr got=%b exp=1", Sys_Intr); bad++; end
  endtask

  task automatic test_no_hit();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    xfer(32'hA900_3000, 1, 32'h0, 1, 8'h55, 1, 0, 0, 12, a, e, r, d, c, q, ce);
    total++; if ({a, r} !== 2'b00 || q !== 0 || ce !== 0) begin $display("FAIL nohit_ch3 got=ack%b/rty%b/req%0d/ce%0d exp=0/0/0/0", a, r, q, ce); bad++; end
    xfer(32'hA800_0000, 0, 32'h0, 1, 8'h55, 1, 0, 0, 12, a, e, r, d, c, q, ce);
    total++; if ({a, r} !== 2'b00 || q !== 0 || ce !== 0) begin $display("FAIL nohit_base got=ack%b/rty%b/req%0d/ce%0d exp=0/0/0/0", a, r, q, ce); bad++; end
    tick();
  endtask

  task automatic test_drop_select();
    int acks = 0;
    OPB_ABus = 32'hA900_0008; OPB_RNW = 1; OPB_select = 1;
    tick(); tick(); tick();  // now in WAIT
    total++; if (Bus2IP_RegCE !== 16'h0004) begin $display("FAIL drop_ce_live got=%h exp=0004", Bus2IP_RegCE); bad++; end
    OPB_select = 0;
    tick();
    total++; if (Bus2IP_RegCE !== 16'h0) begin $display("FAIL drop_ce_clr got=%h exp=0", Bus2IP_RegCE); bad++; end
    IP2Bus_RdAck = 1; IP2Bus_Data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) IP2Bus_RdAck = 0;
      if (Sl_xferAck || Sl_errAck || Sl_retry) acks++;
    end
    total++; if (acks !== 0) begin $display("FAIL drop_late_ack got=%0d exp=0", acks); bad++; end
  endtask

  task automatic test_reset_mid_wait();
    logic a, e, r; logic [31:0] d; int c, q, ce;
    IP2Bus_ToutSup = 1;
    OPB_ABus = 32'hA900_1000; OPB_RNW = 1; OPB_select = 1;
    tick(); tick(); tick();
    total++; if (Sl_toutSup !== 1'b1) begin $display("FAIL toutsup_wait got=%b exp=1", Sl_toutSup); bad++; end
    #2 rst_n = 0;
    #1;
    total++; if ({Bus2IP_RegCE, Bus2IP_Addr} !== 48'h0) begin $display("FAIL rstmid_latches got=%h exp=0", {Bus2IP_RegCE, Bus2IP_Addr}); bad++; end
    total++; if ({Sl_toutSup, Sys_Intr, Sl_xferAck, Sl_errAck, Sl_retry} !== 5'b0) begin $display("FAIL rstmid_outs got=%b exp=00000", {Sl_toutSup, Sys_Intr, Sl_xferAck, Sl_errAck, Sl_retry}); bad++; end
    OPB_select = 0; IP2Bus_ToutSup = 0; IP2Bus_Intr = 2'b00;
    tick();
    rst_n = 1;
    tick(); tick();
    total++; if (Sl_xferAck !== 1'b0) begin $display("FAIL rstmid_noresp got=%b exp=0", Sl_xferAck); bad++; end
    xfer(32'hA900_0000, 1, 32'h0, 1, 8'h81, 1, 0, 0, 40, a, e, r, d, c, q, ce);
    total++; if ({a, e} !== 2'b10 || c !== 5 || d !== 32'h8100_0000) begin $display("FAIL rstmid_recover got=%b/cyc%0d/%h exp=10/cyc5/81000000", {a, e}, c, d); bad++; end
    tick();
  endtask

  initial begin
    rst_n = 0;
    OPB_ABus = '0; OPB_DBus = '0; OPB_BE = '0; OPB_RNW = 0; OPB_select = 0; OPB_seqAddr = 0;
    IP2Bus_Data = '0; IP2Bus_RdAck = 0; IP2Bus_WrAck = 0; IP2Bus_Error = 0;
    IP2Bus_Retry = 0; IP2Bus_ToutSup = 0; IP2Bus_Intr = '0;
    tick(); tick(); tick();
    test_reset();
    rst_n = 1;
    tick();
    test_read();
    test_write_err();
    test_timeout();
    test_retry();
    test_interrupts();
    test_no_hit();
    test_drop_select();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/opb_ipif_slv_ps2_reg_multi.md
Name: opb_ipif_slv_ps2_reg_multi

Overview:
- Next-generation OPB slave IPIF for a bank of PS/2 controllers.
- Generalises the dual-port register interface to C_NUM_CH channels and a C_DWIDTH-bit register lane.
- Adds a request/acknowledge state machine with an IP ack-timeout watchdog, and a local interrupt controller (ISR/IER/GIE) that merges per-channel interrupts into one system interrupt.
- Sits between the OPB bus and the PS/2 channel register files.

Parameters:
C_BASEADDR, 32'hA900_0000, base address; low 16 bits must be zero (64 KB aligned).
C_NUM_CH, 2, number of PS/2 channels, 1..8.
C_DWIDTH, 8, register data width, 8/16/32; occupies OPB bits [0:C_DWIDTH-1].
C_ACK_TIMEOUT, 16, cycles in WAIT before the block self-terminates with errAck, 2..255.

Ports:
OPB_Clk  in  1  bus clock; all logic on its rising edge.
OPB_Rst_n  in  1  asynchronous, active-low reset.
OPB_ABus  in  32  address, [0:31].
OPB_BE  in  4  byte enables, forwarded.
OPB_DBus  in  32  write data.
OPB_RNW  in  1  1 = read.
OPB_select  in  1  transfer valid.
OPB_seqAddr  in  1  ignored; every beat is a single transfer.
Sl_DBus  out  32  read data, zero outside RESP.
Sl_DBusEn  out  1  constant 1.
Sl_xferAck / Sl_errAck / Sl_retry / Sl_toutSup  out  1 each  OPB slave responses.
Sys_Intr  out  1  merged interrupt, registered.
IP2Bus_Data  in  C_DWIDTH  read data from the selected channel.
IP2Bus_RdAck / IP2Bus_WrAck / IP2Bus_Error / IP2Bus_Retry / IP2Bus_ToutSup  in  1 each  IP responses.
IP2Bus_Intr  in  C_NUM_CH  per-channel level interrupts.
Bus2IP_Addr  out  32  latched address.
Bus2IP_BE  out  4  latched byte enables.
Bus2IP_Data  out  C_DWIDTH  latched OPB_DBus[0:C_DWIDTH-1].
Bus2IP_RegCE  out  C_NUM_CH*8  one-hot CE, index = ch*8 + reg.
Bus2IP_RdReq / Bus2IP_WrReq  out  1 each  single-cycle request pulses.

Behaviour:
- Reset (OPB_Rst_n = 0): every output and register is 0, FSM goes to IDLE, ISR/IER/GIE are 0. Sl_DBusEn stays 1.
- Address decode:
  - hit = ABus[0:15]==C_BASEADDR[31:16] and ch=ABus[16:19] <= C_NUM_CH and ABus[20:26]==0.
  - reg = ABus[27:29]; ABus[30:31] are ignored.
  - ch == C_NUM_CH selects the local interrupt slot: reg0 ISR, reg1 IER, reg2 GIE (bit C_DWIDTH-1). Other regs in this slot read 0 and ignore writes.
- FSM states: IDLE, DECODE, REQ, WAIT, RESP.
  - IDLE: select & hit -> DECODE. Latch Addr, BE, Data, RNW, and the CE vector (all zero for the local slot).
  - DECODE: local slot -> RESP (local read data captured). Otherwise -> REQ.
  - REQ: pulse RdReq or WrReq for exactly 1 cycle -> WAIT; clear the timeout counter.
  - WAIT: on (RNW ? RdAck : WrAck), capture IP2Bus_Data and Error -> RESP(ack). If Retry and no ack -> RESP(retry). If counter == C_ACK_TIMEOUT-1 -> RESP(err). Otherwise increment the counter.
  - RESP: for one cycle, assert xferAck (with errAck if Error or timeout) or retry alone. Drive Sl_DBus[0:C_DWIDTH-1] on reads only. -> IDLE; the CE vector clears.
- Ack and Retry in the same cycle: ack wins.
- Sl_toutSup = registered IP2Bus_ToutSup while in REQ or WAIT, else 0.
- Loss of select in DECODE, REQ or WAIT: abort to IDLE next cycle with no response and CE cleared. A late IP ack after the abort is ignored.
- Latency: with an IP that acks the cycle after REQ, xferAck is high in the 5th cycle counting the select-sampled cycle as 1. A local-slot access gives xferAck in cycle 3.
- Interrupts (channel i):
  - ISR[i] sets on a rising edge of IP2Bus_Intr[i], using a registered previous value.
  - Writing 1 to ISR[i] clears it; set and clear in the same cycle -> set wins.
  - ISR/IER bits sit at data bits [C_DWIDTH-C_NUM_CH : C_DWIDTH-1], with channel 0 at the LSB.
  - Sys_Intr <= GIE & |(ISR & IER).
- A reset asserted mid-transfer returns everything to reset values immediately (asynchronous); no response is issued.

Decomposition:
- Package ps2_ipif_pkg: FSM state encoding, local register offsets (ISR=0, IER=1, GIE=2), channel stride log2 = 12, local-slot index rule.
- Sub-module ps2_intr_ctrl: edge detect, ISR/IER/GIE, Sys_Intr register, local read mux.
- The FSM, decode and timeout counter stay in the top module.

Test Plan:
- C_NUM_CH=2, C_DWIDTH=8: read 0xA900_1008, IP acks 1 cycle after RdReq with 0x5A -> RegCE[10]=1, one RdReq pulse, xferAck in cycle 5, Sl_DBus=0x5A00_0000.
- Write 0xA900_0004 data 0x3C00_0000, IP raises WrAck plus Error -> Bus2IP_Data=0x3C, Sl_xferAck and Sl_errAck high together for 1 cycle.
- IP never acks -> after 16 WAIT cycles: xferAck+errAck for 1 cycle, FSM returns to IDLE, a second transfer works normally.
- Retry: IP2Bus_Retry in WAIT -> Sl_retry high 1 cycle, no xferAck. Ack and Retry together -> xferAck only.
- Interrupts: IER=0x03, GIE=0x01, rising edge on IP2Bus_Intr[1] -> ISR reads 0x02, Sys_Intr=1. Write ISR=0x02 -> Sys_Intr=0. Clear coinciding with a new edge -> bit stays 1.
- Access 0xA900_3000 (ch 3 > C_NUM_CH) -> no hit, no RegCE, no response. Drop select in WAIT -> no ack, and a later IP ack is ignored. Reset mid-WAIT -> all outputs 0.
